// File: rtl/alu_seq.sv
// alu_seq: clocked, parametrised ALU with a valid/ready operand handshake
// and a held result.
//
// Operands are accepted in IDLE. Single-cycle ops register RESULT/ZERO/CARRY
// on the accept edge and enter HOLD. Multiply runs an iterative shift-add in
// MUL, one multiplier bit per cycle, and then enters HOLD. HOLD keeps the
// result stable until OUT_READY is seen.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   - opcode 101 is an unsigned WIDTH x WIDTH multiply (WIDTH+1 cycles)
//   undefined - no multiplier or MUL state; opcode 101 returns RESULT=0,
//               ZERO=1, CARRY=1 after one cycle (unsupported-op flag)
//
// Ports:
//   CLK, RESETN          clock (rising edge), async active-low reset
//   IN_VALID / IN_READY  operand handshake; IN_READY=1 only in IDLE
//   DATA1, DATA2         operands (DATA2[SHW-1:0] is the shift amount)
//   SELECT               opcode
//   OUT_VALID/OUT_READY  result handshake
//   RESULT, ZERO, CARRY  registered result and flags
//   BUSY                 state != IDLE
//
// state | meaning
// IDLE  | ready for an operation
// MUL   | iterative multiply in progress (ALU_SEQ_MUL_EN only)
// HOLD  | result valid, waiting for OUT_READY

module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BUSY
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_HOLD = 2'd2} state_t;
  localparam int CNT_W = SHW + 1;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Single-cycle datapath, evaluated directly on the inputs at the accept edge.
  logic [WIDTH:0]   add_ext, sub_ext, sll_ext, sra_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  always_comb begin
    add_ext = {1'b0, DATA1} + {1'b0, DATA2};
    sub_ext = {1'b0, DATA1} - {1'b0, DATA2};
    // One extra bit on the exit side catches the last bit shifted out;
    // with a zero amount that bit stays 0.
    sll_ext = {1'b0, DATA1} << DATA2[SHW-1:0];
    sra_ext = $signed({DATA1, 1'b0}) >>> DATA2[SHW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    case (SELECT)
      3'b000: alu_res = DATA2;
      3'b001: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
      end
      3'b010: alu_res = DATA1 & DATA2;
      3'b011: alu_res = DATA1 | DATA2;
      3'b100: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
      end
      3'b101: begin
        alu_res   = '0;
        alu_carry = 1'b1;
      end
      3'b110: begin
        alu_res   = sll_ext[WIDTH-1:0];
        alu_carry = sll_ext[WIDTH];
      end
      default: begin
        alu_res   = sra_ext[WIDTH:1];
        alu_carry = sra_ext[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
`ifdef ALU_SEQ_MUL_EN
          if (SELECT == 3'b101) begin
            mcand_d  = {{WIDTH{1'b0}}, DATA1};
            mplier_d = DATA2;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            state_d  = ST_HOLD;
          end
`else
          result_d = alu_res;
          carry_d  = alu_carry;
          zero_d   = (alu_res == '0);
          state_d  = ST_HOLD;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        // WIDTH step cycles followed by one cycle that publishes the product.
        if (cnt_q == '0) begin
          result_d = acc_q[WIDTH-1:0];
          carry_d  = |acc_q[2*WIDTH-1:WIDTH];
          zero_d   = (acc_q[WIDTH-1:0] == '0);
          state_d  = ST_HOLD;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_HOLD: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;
  assign RESULT    = result_q;
  assign ZERO      = zero_q;
  assign CARRY     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed vector table,
// backpressure and mid-operation reset sequences, then randomized ops
// against a plain-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = W + 1;
  localparam bit MUL_EN = 1'b1;
`else
  localparam int MUL_LAT = 1;
  localparam bit MUL_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] DATA1 = '0;
  logic [W-1:0] DATA2 = '0;
  logic [2:0]   SELECT = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] RESULT;
  logic         ZERO;
  logic         CARRY;
  logic         BUSY;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference model: straight arithmetic on integers.
  function automatic void model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c);
    int unsigned ua = a;
    int unsigned ub = b;
    int amt = int'(b) % W;
    int sa;
    longint unsigned prod;
    sa = $signed(a);
    r = '0;
    c = 1'b0;
    case (sel)
      3'd0: r = b;
      3'd1: begin r = W'((ua + ub) % 256); c = (ua + ub) > 255; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = W'((ua + 256 - ub) % 256); c = ua < ub; end
      3'd5: begin
        if (MUL_EN) begin
          prod = longint'(ua) * longint'(ub);
          r = W'(prod % 256);
          c = prod > 255;
        end else begin
          r = '0;
          c = 1'b1;
        end
      end
      3'd6: begin
        r = W'((ua << amt) % 256);
        c = (amt == 0) ? 1'b0 : 1'(((ua >> (W - amt)) & 1) != 0);
      end
      default: begin
        r = W'(sa >>> amt);
        c = (amt == 0) ? 1'b0 : 1'(((ua >> (amt - 1)) & 1) != 0);
      end
    endcase
  endfunction

  // Issue one op from IDLE, wait for OUT_VALID, check result/latency/handshake.
  // When do_release is set the result is accepted and the return to IDLE checked.
  task automatic run_op(input string name, input logic [2:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eres, input logic ez,
                        input logic ec, input int elat, input bit do_release);
    int lat;
    bit ready_seen;
    @(negedge CLK);
    check({name, ".in_ready_idle"}, IN_READY, 1);
    IN_VALID = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0; DATA1 = W'($urandom); DATA2 = W'($urandom); SELECT = 3'($urandom);
    lat = 1;
    ready_seen = 1'b0;
    while (!OUT_VALID && lat < 40) begin
      if (IN_READY || !BUSY) ready_seen = 1'b1;
      @(negedge CLK);
      lat++;
    end
    check({name, ".latency"}, lat, elat);
    check({name, ".in_ready_low"}, ready_seen | IN_READY, 0);
    check({name, ".result"}, RESULT, eres);
    check({name, ".zero"}, ZERO, ez);
    check({name, ".carry"}, CARRY, ec);
    if (do_release) begin
      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
      check({name, ".out_valid_drop"}, OUT_VALID, 0);
      check({name, ".in_ready_back"}, IN_READY, 1);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [W-1:0] a, b, res;
    logic z, c;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [W-1:0] hr;
    logic hz, hc;

    // Reset state
    #12;
    check("rst.in_ready", IN_READY, 1);
    check("rst.out_valid", OUT_VALID, 0);
    check("rst.busy", BUSY, 0);
    check("rst.result", RESULT, 0);
    check("rst.zero", ZERO, 0);
    check("rst.carry", CARRY, 0);
    @(negedge CLK);
    RESETN = 1'b1;

    vecs.push_back('{"fwd",      3'd0, 8'd5,   8'd25,  8'd25,  1'b0, 1'b0});
    vecs.push_back('{"add_c",    3'd1, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1});
    vecs.push_back('{"sub_b",    3'd4, 8'd5,   8'd10,  8'd251, 1'b0, 1'b1});
    vecs.push_back('{"sub_z",    3'd4, 8'd7,   8'd7,   8'd0,   1'b1, 1'b0});
    vecs.push_back('{"sll1",     3'd6, 8'hC1,  8'd1,   8'h82,  1'b0, 1'b1});
    vecs.push_back('{"sra3",     3'd7, 8'h80,  8'd3,   8'hF0,  1'b0, 1'b0});
    vecs.push_back('{"and_z",    3'd2, 8'd240, 8'd15,  8'd0,   1'b1, 1'b0});
    vecs.push_back('{"or",       3'd3, 8'd63,  8'd31,  8'd63,  1'b0, 1'b0});
    vecs.push_back('{"sll0",     3'd6, 8'hFF,  8'd8,   8'hFF,  1'b0, 1'b0});
    vecs.push_back('{"sll7",     3'd6, 8'h03,  8'd7,   8'h80,  1'b0, 1'b1});
    vecs.push_back('{"sra1",     3'd7, 8'h81,  8'd1,   8'hC0,  1'b0, 1'b1});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{"mul_255",  3'd5, 8'd15,  8'd17,  8'd255, 1'b0, 1'b0});
    vecs.push_back('{"mul_ovf",  3'd5, 8'd16,  8'd16,  8'd0,   1'b1, 1'b1});
    vecs.push_back('{"mul_max",  3'd5, 8'd255, 8'd255, 8'h01,  1'b0, 1'b1});
`else
    vecs.push_back('{"mul_unsup", 3'd5, 8'd15, 8'd17,  8'd0,   1'b1, 1'b1});
`endif

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z,
             vecs[i].c, (vecs[i].sel == 3'd5) ? MUL_LAT : 1, 1'b1);

    // Backpressure: result held while inputs wiggle, then released.
    run_op("bp", 3'd1, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      IN_VALID = 1'($urandom); DATA1 = W'($urandom); DATA2 = W'($urandom);
      @(negedge CLK);
      check("bp.hold", {OUT_VALID, IN_READY, BUSY, RESULT, ZERO, CARRY}, {1'b1, 1'b0, 1'b1, 8'd44, 1'b0, 1'b1});
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("bp.release", {OUT_VALID, IN_READY, BUSY}, {1'b0, 1'b1, 1'b0});

    // OUT_READY held high before the result arrives is harmless.
    OUT_READY = 1'b1;
    run_op("early_rdy", 3'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1, 1'b0);
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("early_rdy.idle", {OUT_VALID, IN_READY}, {1'b0, 1'b1});

    // Reset in the middle of an operation.
    @(negedge CLK);
    IN_VALID = 1'b1; SELECT = MUL_EN ? 3'd5 : 3'd1; DATA1 = 8'd15; DATA2 = 8'd17;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (MUL_EN ? 3 : 0) @(negedge CLK);
    RESETN = 1'b0;
    #1;
    check("midrst.outputs", {OUT_VALID, BUSY, IN_READY, RESULT, ZERO, CARRY},
          {1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0});
    @(negedge CLK);
    RESETN = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge CLK);
      check("midrst.no_stale", {OUT_VALID, BUSY, IN_READY}, {1'b0, 1'b0, 1'b1});
    end
    run_op("post_rst_add", 3'd1, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1, 1'b1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0] s;
      logic [W-1:0] a, b;
      s = 3'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      if (n % 10 == 0) b = W'(0);
      model(s, a, b, hr, hc);
      hz = (hr == '0);
      run_op($sformatf("rnd%0d_op%0d", n, s), s, a, b, hr, hz, hc,
             (s == 3'd5) ? MUL_LAT : 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the processor's combinational 8-bit ALU.
- Registers operands on a valid/ready input handshake and executes forward, add, AND, OR, sub, multiply and shifts.
- Holds a registered RESULT with ZERO/CARRY flags until the consumer accepts it.
- Sits between the register file read ports and the writeback path; multi-cycle ops stall issue via IN_READY.

Parameters:
- WIDTH, 8, operand/result width; power of two, 4 to 32.
- SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden).

Ports:
- CLK  input  1  clock, rising edge.
- RESETN  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operands/SELECT valid.
- IN_READY  output  1  block can accept an operation.
- DATA1  input  WIDTH  first operand.
- DATA2  input  WIDTH  second operand; also the shift amount source.
- SELECT  input  3  opcode.
- OUT_VALID  output  1  RESULT/flags valid.
- OUT_READY  input  1  consumer accepts the result.
- RESULT  output  WIDTH  registered result.
- ZERO  output  1  RESULT == 0.
- CARRY  output  1  carry, borrow, overflow or shifted-out bit, depending on opcode.
- BUSY  output  1  block not in IDLE.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; RESULT=0; ZERO=0; CARRY=0; OUT_VALID=0; BUSY=0; IN_READY=1.
- Reset mid-operation aborts it; no result is produced.
- Opcodes and results:
  - 000 forward: RESULT=DATA2.
  - 001 add: RESULT=DATA1+DATA2 mod 2^WIDTH; CARRY=carry out.
  - 010 AND; 011 OR: CARRY=0.
  - 100 sub: RESULT=DATA1-DATA2 mod 2^WIDTH; CARRY=1 iff DATA1<DATA2 (unsigned borrow).
  - 101 mul: unsigned; RESULT=low WIDTH bits; CARRY=1 iff the high WIDTH bits are nonzero.
  - 110 SLL by DATA2[SHW-1:0].
  - 111 SRA by DATA2[SHW-1:0].
  - Shifts: CARRY=last bit shifted out; CARRY=0 when the amount is 0.
- ZERO is registered together with RESULT in every case.
- States:
  - IDLE: IN_READY=1. On IN_VALID, latch DATA1/DATA2/SELECT. SELECT=101 goes to MUL; every other opcode computes and goes to HOLD.
  - MUL: iterative shift-add, one multiplier bit per cycle, WIDTH cycles; then HOLD.
  - HOLD: OUT_VALID=1; RESULT/flags stable. On OUT_READY go to IDLE with OUT_VALID=0 the next cycle.
- IN_READY=1 only in IDLE. Input changes outside an accept cycle are ignored; latched operands are used throughout.
- Latency, measured from the accept edge to OUT_VALID=1:
  - Single-cycle ops: 1 cycle.
  - mul: WIDTH+1 cycles.
- Minimum issue interval: 2 cycles, because a new op cannot be accepted in HOLD.
- OUT_READY=1 before OUT_VALID is harmless. HOLD lasts indefinitely under backpressure.
- BUSY = state != IDLE.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 101 performs the multi-cycle multiply described above.
- Undefined:
  - No multiplier datapath and no MUL state.
  - Opcode 101 completes in 1 cycle with RESULT=0, ZERO=1, CARRY=1. CARRY=1 flags an unsupported op.

Test Plan:
1. WIDTH=8, forward with DATA1=5, DATA2=25 -> RESULT=25, ZERO=0, CARRY=0, OUT_VALID exactly 1 cycle after accept.
2. add 200+100 -> RESULT=44, CARRY=1. sub 5-10 -> RESULT=251, CARRY=1. sub 7-7 -> RESULT=0, ZERO=1, CARRY=0.
3. Shifts:
   - SLL 8'hC1 by 1 -> 8'h82, CARRY=1.
   - SRA 8'h80 by 3 -> 8'hF0, CARRY=0.
   - AND 240&15 -> 0, ZERO=1.
   - OR 63|31 -> 63.
4. mul with ALU_SEQ_MUL_EN:
   - 15*17 -> 255, CARRY=0; OUT_VALID 9 cycles after accept; IN_READY=0 throughout.
   - 16*16 -> 0, ZERO=1, CARRY=1.
   - Without the macro: 101 -> RESULT=0, CARRY=1 after 1 cycle.
5. Backpressure: hold OUT_READY=0 for 5 cycles while toggling DATA1/DATA2/IN_VALID -> RESULT/flags stable, IN_READY=0. Release -> OUT_VALID drops next cycle and IN_READY returns to 1.
6. Assert RESETN=0 in mid-multiply cycle 4 -> outputs zero immediately, IN_READY=1 after release, no stale OUT_VALID. A subsequent add 1+2 -> RESULT=3.
